// File: rtl/alu_steuerwerk_if.sv
// Bundle of request, ALU and result signals between the sequencer and its neighbours.
// The slave modport is the sequencer's view. The master modport is the environment's view.
interface alu_steuerwerk_if #(
    parameter int DATENBREITE = 32
);
    logic                   auftragGueltig;
    logic                   auftragBereit;
    logic [5:0]             funktionscode;
    logic [DATENBREITE-1:0] daten1;
    logic [DATENBREITE-1:0] daten2;

    logic [5:0]             aluFunktionscode;
    logic [DATENBREITE-1:0] aluDaten1;
    logic [DATENBREITE-1:0] aluDaten2;
    logic                   aluStart;
    logic                   aluSchreiben;
    logic                   divFertig;
    logic                   wurzelFertig;
    logic [DATENBREITE-1:0] aluErgebnis;

    logic                   ergebnisGueltig;
    logic                   ergebnisBereit;
    logic [DATENBREITE-1:0] ergebnis;
    logic                   fehler;

    modport slave (
        input  auftragGueltig, funktionscode, daten1, daten2,
        input  divFertig, wurzelFertig, aluErgebnis, ergebnisBereit,
        output auftragBereit, aluFunktionscode, aluDaten1, aluDaten2,
        output aluStart, aluSchreiben, ergebnisGueltig, ergebnis, fehler
    );

    modport master (
        output auftragGueltig, funktionscode, daten1, daten2,
        output divFertig, wurzelFertig, aluErgebnis, ergebnisBereit,
        input  auftragBereit, aluFunktionscode, aluDaten1, aluDaten2,
        input  aluStart, aluSchreiben, ergebnisGueltig, ergebnis, fehler
    );
endinterface

// File: rtl/alu_steuerwerk.sv
// alu_steuerwerk: sequencer in front of the ALU.
// It accepts one operation at a time, then pulses the ALU start and write strobes.
// For sqrt, div and mod it waits on the matching done flag, bounded by a timeout.
// It returns a registered result and an error flag.
// Optional macro ALU_STEUERWERK_DURCHREICHEN_EN: a new request may be accepted
// on the same edge as the result handoff, which removes the idle cycle in LEER.
module alu_steuerwerk #(
    parameter int DATENBREITE    = 32,
    parameter int TIMEOUT_ZYKLEN = 64,
    parameter int ZAEHLER_BREITE = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_steuerwerk_if.slave  bus
);

    typedef enum logic [2:0] {
        LEER,
        START,
        WARTEN,
        SCHREIBEN,
        ERFASSEN,
        AUSGABE
    } zustand_t;

    typedef enum logic [1:0] {
        KLASSE_EINZEL,
        KLASSE_WURZEL,
        KLASSE_DIV,
        KLASSE_ILLEGAL
    } klasse_t;

    localparam logic [ZAEHLER_BREITE-1:0] ZAEHLER_ENDE = ZAEHLER_BREITE'(TIMEOUT_ZYKLEN - 1);

    // Bit 5 marks float codes, which are not supported.
    // The listed single-cycle and multi-cycle codes are legal. Every other code is illegal.
    function automatic klasse_t klassifiziere(input logic [5:0] code);
        klasse_t k;
        if (code[5]) begin
            k = KLASSE_ILLEGAL;
        end else begin
            case (code[4:0])
                5'd0, 5'd1, 5'd2,
                5'd6, 5'd7, 5'd8, 5'd9,
                5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21,
                5'd24, 5'd25, 5'd26, 5'd27, 5'd28:  k = KLASSE_EINZEL;
                5'd3:                               k = KLASSE_WURZEL;
                5'd4, 5'd5:                         k = KLASSE_DIV;
                default:                            k = KLASSE_ILLEGAL;
            endcase
        end
        return k;
    endfunction

    zustand_t                  zustand;
    klasse_t                   klasse;
    logic [5:0]                codeReg;
    logic [DATENBREITE-1:0]    daten1Reg;
    logic [DATENBREITE-1:0]    daten2Reg;
    logic [ZAEHLER_BREITE-1:0] zaehler;
    logic                      aluStartReg;
    logic                      aluSchreibenReg;
    logic                      gueltigReg;
    logic [DATENBREITE-1:0]    ergebnisReg;
    logic                      fehlerReg;
    logic                      bereitReg;

    logic                      bereit;
    logic                      annahme;
    logic                      fertig;
    klasse_t                   neueKlasse;

    // Ready is high in LEER. With pass-through enabled, ready follows the consumer during the handoff.
`ifdef ALU_STEUERWERK_DURCHREICHEN_EN
    assign bereit = bereitReg | ((zustand == AUSGABE) & bus.ergebnisBereit);
`else
    assign bereit = bereitReg;
`endif

    assign annahme    = bus.auftragGueltig & bereit;
    assign neueKlasse = klassifiziere(bus.funktionscode);
    assign fertig     = (klasse == KLASSE_DIV) ? bus.divFertig : bus.wurzelFertig;

    // Sequencer state, latched operation and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zustand         <= LEER;
            klasse          <= KLASSE_EINZEL;
            codeReg         <= '0;
            daten1Reg       <= '0;
            daten2Reg       <= '0;
            zaehler         <= '0;
            aluStartReg     <= 1'b0;
            aluSchreibenReg <= 1'b0;
            gueltigReg      <= 1'b0;
            ergebnisReg     <= '0;
            fehlerReg       <= 1'b0;
            bereitReg       <= 1'b0;
        end else begin
            aluStartReg     <= 1'b0;
            aluSchreibenReg <= 1'b0;

            case (zustand)
                LEER: begin
                    bereitReg <= 1'b1;
                end

                START: begin
                    zaehler <= '0;
                    if (klasse == KLASSE_EINZEL) begin
                        zustand         <= SCHREIBEN;
                        aluSchreibenReg <= 1'b1;
                    end else begin
                        zustand <= WARTEN;
                    end
                end

                WARTEN: begin
                    zaehler <= zaehler + 1'b1;
                    if (fertig) begin
                        zustand         <= SCHREIBEN;
                        aluSchreibenReg <= 1'b1;
                    end else if (zaehler == ZAEHLER_ENDE) begin
                        zustand     <= AUSGABE;
                        ergebnisReg <= '0;
                        fehlerReg   <= 1'b1;
                        gueltigReg  <= 1'b1;
                    end
                end

                SCHREIBEN: begin
                    zustand <= ERFASSEN;
                end

                ERFASSEN: begin
                    zustand     <= AUSGABE;
                    ergebnisReg <= bus.aluErgebnis;
                    fehlerReg   <= 1'b0;
                    gueltigReg  <= 1'b1;
                end

                AUSGABE: begin
                    if (bus.ergebnisBereit) begin
                        zustand    <= LEER;
                        gueltigReg <= 1'b0;
                        bereitReg  <= 1'b1;
                    end
                end

                default: begin
                    zustand <= LEER;
                end
            endcase

            if (annahme) begin
                codeReg   <= bus.funktionscode;
                daten1Reg <= bus.daten1;
                daten2Reg <= bus.daten2;
                klasse    <= neueKlasse;
                bereitReg <= 1'b0;
                if (neueKlasse == KLASSE_ILLEGAL) begin
                    zustand     <= AUSGABE;
                    ergebnisReg <= '0;
                    fehlerReg   <= 1'b1;
                    gueltigReg  <= 1'b1;
                end else begin
                    zustand     <= START;
                    aluStartReg <= 1'b1;
                    gueltigReg  <= 1'b0;
                end
            end
        end
    end

    assign bus.auftragBereit    = bereit;
    assign bus.aluFunktionscode = codeReg;
    assign bus.aluDaten1        = daten1Reg;
    assign bus.aluDaten2        = daten2Reg;
    assign bus.aluStart         = aluStartReg;
    assign bus.aluSchreiben     = aluSchreibenReg;
    assign bus.ergebnisGueltig  = gueltigReg;
    assign bus.ergebnis         = ergebnisReg;
    assign bus.fehler           = fehlerReg;

endmodule
